// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore sequencer over fetch/decode/execute/memory/writeback.
// State-only selects are registered alongside the state; opcode/funct/zero/mem_ready qualify a few outputs directly.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic [2:0] alu_control,
    output logic       illegal_op
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       fetch;
        logic       decode;
        logic       exec;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       is_load_q, is_load_d;
    logic       op_legal, fn_legal;
    logic [2:0] fn_alu;

    always_comb begin
        fn_legal = 1'b1;
        fn_alu   = 3'b010;
        unique case (funct)
            6'b100100: fn_alu = 3'b000;
            6'b100101: fn_alu = 3'b001;
            6'b100000: fn_alu = 3'b010;
            6'b100010: fn_alu = 3'b110;
            6'b101010: fn_alu = 3'b111;
            default:   fn_legal = 1'b0;
        endcase
    end

    assign op_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                      (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);

    // Memory handshake: FETCH, MEMRD and MEMWR hold their request until mem_ready is seen high.
    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        unique case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                is_load_d = (opcode == OP_LW);
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = is_load_q ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXECUTE: state_d = fn_legal ? S_ALUWB : S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            S_FETCH:   begin ctrl_d.mem_read = 1'b1; ctrl_d.alu_src_b = 2'b01;
                             ctrl_d.alu_op = 3'b010; ctrl_d.fetch = 1'b1; end
            S_DECODE:  begin ctrl_d.alu_src_b = 2'b11; ctrl_d.alu_op = 3'b010; ctrl_d.decode = 1'b1; end
            S_MEMADR,
            S_ADDIEX:  begin ctrl_d.alu_src_a = 1'b1; ctrl_d.alu_src_b = 2'b10; ctrl_d.alu_op = 3'b010; end
            S_MEMRD:   begin ctrl_d.mem_read = 1'b1; ctrl_d.iord = 1'b1; end
            S_MEMWB:   begin ctrl_d.mem_to_reg = 1'b1; ctrl_d.reg_write = 1'b1; end
            S_MEMWR:   begin ctrl_d.mem_write = 1'b1; ctrl_d.iord = 1'b1; end
            S_EXECUTE: begin ctrl_d.alu_src_a = 1'b1; ctrl_d.exec = 1'b1; end
            S_ALUWB:   begin ctrl_d.reg_dst = 1'b1; ctrl_d.reg_write = 1'b1; end
            S_BRANCH:  begin ctrl_d.alu_src_a = 1'b1; ctrl_d.alu_op = 3'b110;
                             ctrl_d.pc_src = 2'b01; ctrl_d.branch = 1'b1; end
            S_ADDIWB:  ctrl_d.reg_write = 1'b1;
            S_JUMP:    begin ctrl_d.pc_src = 2'b10; ctrl_d.pc_write = 1'b1; end
            default:   ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            ctrl_q    <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            is_load_q <= is_load_d;
        end
    end

    assign mem_read    = ctrl_q.mem_read;
    assign mem_write   = ctrl_q.mem_write;
    assign iord        = ctrl_q.iord;
    assign reg_dst     = ctrl_q.reg_dst;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign reg_write   = ctrl_q.reg_write;
    assign alu_src_a   = ctrl_q.alu_src_a;
    assign alu_src_b   = ctrl_q.alu_src_b;
    assign pc_src      = ctrl_q.pc_src;
    assign alu_control = ctrl_q.exec ? fn_alu : ctrl_q.alu_op;
    assign ir_write    = ctrl_q.fetch & mem_ready;
    assign pc_en       = (ctrl_q.fetch & mem_ready) | ctrl_q.pc_write | (ctrl_q.branch & zero);
    assign illegal_op  = (ctrl_q.decode & ~op_legal) | (ctrl_q.exec & ~fn_legal);
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expected output vectors are queued per instruction, then compared cycle by cycle.
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       mem_read, mem_write, ir_write, iord, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       pc_en, illegal_op;
    logic [2:0] alu_control;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .iord(iord), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc_en(pc_en), .alu_control(alu_control), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    localparam int W = 17;
    logic [W-1:0] obs;
    assign obs = {mem_read, mem_write, ir_write, iord, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, pc_src, pc_en, alu_control, illegal_op};

    typedef struct packed {
        logic rdy;
        logic z;
        logic real_ir;
    } stim_t;

    logic [W-1:0] exp_q[$];
    stim_t        stim_q[$];
    string        tag_q[$];
    logic [5:0]   cur_op, cur_fn;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (mr mw irw iord rd m2r rw asa asb pcs pce alu ill)",
                     tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] vec(input logic mr, mw, irw, io, rd, m2r, rw, asa,
                                         input logic [1:0] asb, pcs, input logic pce,
                                         input logic [2:0] alu, input logic ill);
        return {mr, mw, irw, io, rd, m2r, rw, asa, asb, pcs, pce, alu, ill};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input string tag, input logic [W-1:0] v, input logic rdy, input logic z,
                        input logic real_ir);
        stim_t s;
        s.rdy = rdy; s.z = z; s.real_ir = real_ir;
        exp_q.push_back(v);
        stim_q.push_back(s);
        tag_q.push_back(tag);
    endtask

    // Builds the expected cycle sequence of one instruction from FETCH entry up to the next FETCH entry.
    task automatic gen(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fstall, input int mstall);
        logic       ill;
        logic [2:0] alu;
        cur_op = op;
        cur_fn = fn;
        for (int i = 0; i < fstall; i++)
            push("fetch_wait", vec(1,0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,0), 1'b0, rnd(), 1'b0);
        push("fetch", vec(1,0,1,0,0,0,0,0,2'b01,2'b00,1,3'b010,0), 1'b1, rnd(), 1'b0);
        ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
        push("decode", vec(0,0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,ill), rnd(), rnd(), 1'b1);
        case (op)
            6'b100011: begin
                push("lw_memadr", vec(0,0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0), rnd(), rnd(), 1'b0);
                for (int i = 0; i < mstall; i++)
                    push("lw_memrd_wait", vec(1,0,0,1,0,0,0,0,2'b00,2'b00,0,3'b000,0), 1'b0, rnd(), 1'b0);
                push("lw_memrd", vec(1,0,0,1,0,0,0,0,2'b00,2'b00,0,3'b000,0), 1'b1, rnd(), 1'b0);
                push("lw_memwb", vec(0,0,0,0,0,1,1,0,2'b00,2'b00,0,3'b000,0), rnd(), rnd(), 1'b0);
            end
            6'b101011: begin
                push("sw_memadr", vec(0,0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0), rnd(), rnd(), 1'b0);
                for (int i = 0; i < mstall; i++)
                    push("sw_memwr_wait", vec(0,1,0,1,0,0,0,0,2'b00,2'b00,0,3'b000,0), 1'b0, rnd(), 1'b0);
                push("sw_memwr", vec(0,1,0,1,0,0,0,0,2'b00,2'b00,0,3'b000,0), 1'b1, rnd(), 1'b0);
            end
            6'b000000: begin
                ill = 1'b0;
                case (fn)
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b100000: alu = 3'b010;
                    6'b100010: alu = 3'b110;
                    6'b101010: alu = 3'b111;
                    default: begin alu = 3'b010; ill = 1'b1; end
                endcase
                push("r_execute", vec(0,0,0,0,0,0,0,1,2'b00,2'b00,0,alu,ill), rnd(), rnd(), 1'b1);
                if (!ill)
                    push("r_aluwb", vec(0,0,0,0,1,0,1,0,2'b00,2'b00,0,3'b000,0), rnd(), rnd(), 1'b0);
            end
            6'b000100:
                push("beq_branch", vec(0,0,0,0,0,0,0,1,2'b00,2'b01,z,3'b110,0), rnd(), z, 1'b0);
            6'b001000: begin
                push("addi_ex", vec(0,0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0), rnd(), rnd(), 1'b0);
                push("addi_wb", vec(0,0,0,0,0,0,1,0,2'b00,2'b00,0,3'b000,0), rnd(), rnd(), 1'b0);
            end
            6'b000010:
                push("jump", vec(0,0,0,0,0,0,0,0,2'b00,2'b10,1,3'b000,0), rnd(), rnd(), 1'b0);
            default: ;
        endcase
    endtask

    // n < 0 drains the whole queue; opcode/funct carry the real instruction only where the DUT may sample them.
    task automatic drain(input int n);
        stim_t        s;
        logic [W-1:0] e;
        string        t;
        int           k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            @(posedge clk);
            #1;
            mem_ready = s.rdy;
            zero      = s.z;
            if (s.real_ir) begin
                opcode = cur_op;
                funct  = cur_fn;
            end else begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end
            @(negedge clk);
            check_eq(t, obs, e);
            k++;
        end
    endtask

    logic [5:0] op_tbl[8];
    logic [5:0] fn_tbl[6];
    logic [5:0] rop, rfn;

    initial begin
        op_tbl = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111, 6'b010001};
        fn_tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000001};
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        #3;
        check_eq("por", obs, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_state", obs, '0);

        gen(6'b000000, 6'b100000, 1'b0, 0, 0); drain(-1);
        gen(6'b000000, 6'b100010, 1'b0, 0, 0); drain(-1);
        gen(6'b000000, 6'b100100, 1'b0, 0, 0); drain(-1);
        gen(6'b000000, 6'b100101, 1'b0, 0, 0); drain(-1);
        gen(6'b000000, 6'b101010, 1'b0, 0, 0); drain(-1);
        gen(6'b100011, 6'b000000, 1'b0, 0, 3); drain(-1);
        gen(6'b101011, 6'b000000, 1'b0, 1, 2); drain(-1);
        gen(6'b000100, 6'b000000, 1'b1, 0, 0); drain(-1);
        gen(6'b000100, 6'b000000, 1'b0, 0, 0); drain(-1);
        gen(6'b000010, 6'b000000, 1'b0, 0, 0); drain(-1);
        gen(6'b001000, 6'b000000, 1'b0, 0, 0); drain(-1);
        gen(6'b111111, 6'b000000, 1'b0, 0, 0); drain(-1);
        gen(6'b000000, 6'b000001, 1'b0, 0, 0); drain(-1);

        for (int i = 0; i < 40; i++) begin
            rop = op_tbl[$urandom_range(0, 7)];
            rfn = fn_tbl[$urandom_range(0, 5)];
            gen(rop, rfn, rnd(), $urandom_range(0, 2), $urandom_range(0, 3));
            drain(-1);
        end

        // Abandon a load while it waits in MEMRD.
        gen(6'b100011, 6'b000000, 1'b0, 0, 2);
        drain(3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_eq("async_rst", obs, '0);
        @(negedge clk);
        check_eq("rst_held", obs, '0);
        exp_q.delete(); stim_q.delete(); tag_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_state2", obs, '0);
        gen(6'b001000, 6'b000000, 1'b0, 0, 0); drain(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
